// File: rtl/fp_ctrl_pkg.sv
// Shared constants and types for the front-panel control/status hub.
package fp_ctrl_pkg;

  // Read data returned for an unmapped or write-colliding bridge read.
  localparam logic [31:0] BAD_ADDR_DATA = 32'hBAD0_ADD0;

  // Field offsets inside the wo20 status word.
  localparam int STICKY_LSB = 16;
  localparam int LIVE_LSB   = 0;

  // Where a bridge read will get its data from two cycles later.
  typedef enum logic [1:0] {
    RD_TGT,
    RD_LOCAL,
    RD_BAD
  } rd_kind_e;

  // One stage of the read-return pipeline.
  typedef struct packed {
    logic     valid;
    rd_kind_e kind;
    logic [3:0] idx;
  } rd_stage_t;

  // Width of the target-select field.
  // One extra code beyond the last target is reserved for local space.
  function automatic int sel_width(input int n_tgt);
    return $clog2(n_tgt + 1);
  endfunction

endpackage

// File: rtl/fp_ctrl_hub_if.sv
// Host register-bridge port of the front-panel hub.
// The master drives strobes, address and write data; the slave returns read data.
interface fp_ctrl_hub_if;
  logic        regbridge_ep_write;
  logic        regbridge_ep_read;
  logic [31:0] regbridge_ep_address;
  logic [31:0] regbridge_ep_dataout;
  logic [31:0] regbridge_ep_datain;

  modport master (
    output regbridge_ep_write, regbridge_ep_read, regbridge_ep_address, regbridge_ep_dataout,
    input  regbridge_ep_datain
  );

  modport slave (
    input  regbridge_ep_write, regbridge_ep_read, regbridge_ep_address, regbridge_ep_dataout,
    output regbridge_ep_datain
  );
endinterface

// File: rtl/fp_ctrl_hub_pulse_stretch.sv
// Single-bit trigger stretcher: a one-cycle trigger becomes a STRETCH-cycle pulse.
// A trigger arriving while the pulse is active reloads the count, extending it.
module fp_pulse_stretch #(
  parameter int STRETCH = 4
) (
  input  logic okClk,
  input  logic rst_n,
  input  logic trig,
  output logic pulse
);

  logic [7:0] cnt;

  // Load on trigger, otherwise count down to zero.
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (trig) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      cnt <= 8'(STRETCH);
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign pulse = (cnt != 8'd0);

endmodule

// File: rtl/fp_ctrl_hub.sv
// Front-panel control/status hub (okClk domain): synchronised live/sticky status,
// stretched triggers, registered control bits and a host register-bridge demux.
// Optional feature macro: FP_CTRL_HUB_EVT_CNT_EN adds per-status saturating
// rising-edge counters readable through the local address space (sel == N_TGT).
module fp_ctrl_hub
  import fp_ctrl_pkg::*;
#(
  parameter int N_STATUS     = 8,
  parameter int N_TRIG       = 8,
  parameter int N_CTRL       = 8,
  parameter int N_TGT        = 2,
  parameter int TGT_ADDR_LSB = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int STRETCH      = 4
) (
  input  logic                  okClk,
  input  logic                  rst_n,
  fp_ctrl_hub_if.slave          host,
  output logic [N_TGT-1:0]      tgt_write,
  output logic [N_TGT-1:0]      tgt_read,
  output logic [31:0]           tgt_address,
  output logic [31:0]           tgt_dataout,
  input  logic [32*N_TGT-1:0]   tgt_datain,
  input  logic [31:0]           wi00_ep_dataout,
  output logic [N_CTRL-1:0]     ctrl_out,
  input  logic [31:0]           ti40_ep_trigger,
  output logic [N_TRIG-1:0]     trig_out,
  input  logic [31:0]           ti41_ep_trigger,
  input  logic [N_STATUS-1:0]   status_in,
  output logic [31:0]           wo20_ep_datain
);

  localparam int SEL_W = sel_width(N_TGT);
  localparam logic [31:0] SEL_MASK = 32'(((1 << SEL_W) - 1) << TGT_ADDR_LSB);

  // ---------------- status ----------------
  logic [N_STATUS-1:0] sync_q [SYNC_STAGES];
  logic [N_STATUS-1:0] live, live_prev, live_rise, sticky, sticky_clr;
  logic [31:0]         wo20_next;

  assign live       = sync_q[SYNC_STAGES-1];
  assign live_rise  = live & ~live_prev;
  assign sticky_clr = ti41_ep_trigger[N_STATUS-1:0];

  // Assemble the status word from the current live and sticky vectors.
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    wo20_next = '0;
    wo20_next[STICKY_LSB +: N_STATUS] = sticky;
    wo20_next[LIVE_LSB +: N_STATUS]   = live;
  end

  // Synchroniser chain, edge history, sticky capture and registered status word.
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the synchroniser array is flop state, so each element is reset.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      live_prev      <= '0;
      sticky         <= '0;
      wo20_ep_datain <= '0;
    end else begin
      sync_q[0] <= status_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      live_prev      <= live;
      // Set is OR-ed in after the clear mask, so a same-cycle set wins.
      sticky         <= (sticky & ~sticky_clr) | live_rise;
      wo20_ep_datain <= wo20_next;
    end
  end

  // ---------------- control ----------------
  // Register the control wire-in bits.
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) ctrl_out <= '0;
    else        ctrl_out <= wi00_ep_dataout[N_CTRL-1:0];
  end

  // ---------------- triggers ----------------
  for (genvar g = 0; g < N_TRIG; g++) begin : g_trig
    fp_pulse_stretch #(.STRETCH(STRETCH)) u_stretch (
      .okClk (okClk),
      .rst_n (rst_n),
      .trig  (ti40_ep_trigger[g]),
      .pulse (trig_out[g])
    );
  end

  // ---------------- bridge decode ----------------
  logic [SEL_W-1:0] sel, rd_sel1, rd_sel2;
  logic [N_TGT-1:0] sel_onehot;
  logic             sel_tgt, sel_local;
  rd_kind_e         rd_kind;
  rd_stage_t        rd_q1, rd_q2;
  logic [31:0]      rd_data, datain_q;

  assign sel     = host.regbridge_ep_address[TGT_ADDR_LSB +: SEL_W];
  assign sel_tgt = (int'(sel) < N_TGT);

`ifdef FP_CTRL_HUB_EVT_CNT_EN
  logic [7:0] evt_cnt [N_STATUS];

  assign sel_local = (int'(sel) == N_TGT);

  // Saturating rising-edge counters, cleared together with their sticky bit.
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_STATUS; i++) evt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_STATUS; i++) begin
        if (sticky_clr[i])                             evt_cnt[i] <= live_rise[i] ? 8'd1 : 8'd0;
        else if (live_rise[i] && evt_cnt[i] != 8'hFF) evt_cnt[i] <= evt_cnt[i] + 8'd1;
      end
    end
  end
`else
  assign sel_local = 1'b0;
`endif

  // One-hot strobe select; all-zero when sel points outside the target range.
  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < N_TGT; k++) sel_onehot[k] = (int'(sel) == k);
  end

  // Classify a read: a read colliding with a write is treated as out-of-range.
  always_comb begin
    rd_kind = RD_BAD;
    if (!host.regbridge_ep_write) begin
      if (sel_tgt)        rd_kind = RD_TGT;
      else if (sel_local) rd_kind = RD_LOCAL;
    end
  end

  // Pick the return data for the read leaving the pipeline.
  always_comb begin
    rd_data = BAD_ADDR_DATA;
    case (rd_q2.kind)
      RD_TGT: begin
        for (int k = 0; k < N_TGT; k++)
          if (int'(rd_sel2) == k) rd_data = tgt_datain[32*k +: 32];
      end
      RD_LOCAL: begin
        rd_data = '0;
`ifdef FP_CTRL_HUB_EVT_CNT_EN
        for (int i = 0; i < N_STATUS; i++)
          if (int'(rd_q2.idx) == i) rd_data = 32'(evt_cnt[i]);
`endif
      end
      default: ;
    endcase
  end

  // Target-side registers and the two-stage read-return pipeline.
  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_write   <= '0;
      tgt_read    <= '0;
      tgt_address <= '0;
      tgt_dataout <= '0;
      rd_q1       <= '0;
      rd_q2       <= '0;
      rd_sel1     <= '0;
      rd_sel2     <= '0;
      datain_q    <= '0;
    end else begin
      tgt_write   <= host.regbridge_ep_write ? sel_onehot : '0;
      tgt_read    <= (host.regbridge_ep_read && !host.regbridge_ep_write) ? sel_onehot : '0;
      tgt_address <= host.regbridge_ep_address & ~SEL_MASK;
      tgt_dataout <= host.regbridge_ep_dataout;
      rd_q1.valid <= host.regbridge_ep_read;
      rd_q1.kind  <= rd_kind;
      rd_q1.idx   <= host.regbridge_ep_address[3:0];
      rd_sel1     <= sel;
      rd_q2       <= rd_q1;
      rd_sel2     <= rd_sel1;
      if (rd_q2.valid) datain_q <= rd_data;
    end
  end

  assign host.regbridge_ep_datain = datain_q;

  // Bits that are intentionally not consumed in every configuration.
  logic unused_bits;
  assign unused_bits = ^{ti40_ep_trigger, ti41_ep_trigger, wi00_ep_dataout,
                         host.regbridge_ep_address, rd_q2};

endmodule

// File: tb/tb_fp_ctrl_hub.sv
// Self-checking bench for fp_ctrl_hub: directed scenarios plus randomized traffic,
// all compared every cycle against a history-based reference model.
module tb_fp_ctrl_hub;

  localparam int N_STATUS     = 8;
  localparam int N_TRIG       = 8;
  localparam int N_CTRL       = 8;
  localparam int N_TGT        = 2;
  localparam int TGT_ADDR_LSB = 12;
  localparam int SYNC_STAGES  = 2;
  localparam int STRETCH      = 4;
  localparam int SEL_W        = $clog2(N_TGT + 1);
  localparam int MAXC         = 8192;
  localparam logic [31:0] BAD_WORD = 32'hBAD0_ADD0;

  logic okClk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_TGT-1:0]    tgt_write, tgt_read;
  logic [31:0]         tgt_address, tgt_dataout;
  logic [32*N_TGT-1:0] tgt_datain;
  logic [31:0]         wi00_ep_dataout, ti40_ep_trigger, ti41_ep_trigger, wo20_ep_datain;
  logic [N_CTRL-1:0]   ctrl_out;
  logic [N_TRIG-1:0]   trig_out;
  logic [N_STATUS-1:0] status_in;

  fp_ctrl_hub_if host();

  fp_ctrl_hub #(
    .N_STATUS(N_STATUS), .N_TRIG(N_TRIG), .N_CTRL(N_CTRL), .N_TGT(N_TGT),
    .TGT_ADDR_LSB(TGT_ADDR_LSB), .SYNC_STAGES(SYNC_STAGES), .STRETCH(STRETCH)
  ) dut (
    .okClk(okClk), .rst_n(rst_n), .host(host),
    .tgt_write(tgt_write), .tgt_read(tgt_read), .tgt_address(tgt_address),
    .tgt_dataout(tgt_dataout), .tgt_datain(tgt_datain),
    .wi00_ep_dataout(wi00_ep_dataout), .ctrl_out(ctrl_out),
    .ti40_ep_trigger(ti40_ep_trigger), .trig_out(trig_out),
    .ti41_ep_trigger(ti41_ep_trigger), .status_in(status_in),
    .wo20_ep_datain(wo20_ep_datain)
  );

  always #5 okClk = ~okClk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rst = 0;

  // Input history, indexed by the clock edge that sampled it.
  logic [N_STATUS-1:0] st_h     [MAXC];
  logic [N_TRIG-1:0]   t40_h    [MAXC];
  logic [N_STATUS-1:0] sticky_h [MAXC];
  int                  cnt_m    [N_STATUS];

  typedef struct {int due; int kind; int sel; int idx;} rd_t;  // kind: 0 target, 1 local, 2 bad
  rd_t pend[$];

  logic [31:0] exp_ctrl, exp_trig, exp_wo20, exp_tw, exp_tr, exp_ta, exp_td, exp_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Status level seen on the live vector after edge k: the input SYNC_STAGES-1 edges earlier.
  function automatic logic [N_STATUS-1:0] live_at(input int k);
    int j;
    j = k - SYNC_STAGES + 1;
    if (j <= last_rst) return '0;
    return st_h[j];
  endfunction

  // Advance one clock edge, update the model from the sampled inputs, then compare.
  task automatic cycle();
    logic [N_STATUS-1:0] rise;
    logic [31:0] a;
    int sel;
    rd_t p;
    @(posedge okClk);
    cyc++;
    if (!rst_n) begin
      last_rst = cyc;
      st_h[cyc] = '0; t40_h[cyc] = '0; sticky_h[cyc] = '0;
      for (int i = 0; i < N_STATUS; i++) cnt_m[i] = 0;
      pend.delete();
      exp_ctrl = '0; exp_trig = '0; exp_wo20 = '0; exp_tw = '0;
      exp_tr = '0; exp_ta = '0; exp_td = '0; exp_din = '0;
    end else begin
      st_h[cyc]  = status_in;
      t40_h[cyc] = ti40_ep_trigger[N_TRIG-1:0];
      rise = live_at(cyc-1) & ~live_at(cyc-2);
      sticky_h[cyc] = (sticky_h[cyc-1] & ~ti41_ep_trigger[N_STATUS-1:0]) | rise;

      exp_wo20 = '0;
      exp_wo20[16 +: N_STATUS] = sticky_h[cyc-1];
      exp_wo20[0 +: N_STATUS]  = live_at(cyc-1);
      exp_ctrl = 32'(wi00_ep_dataout[N_CTRL-1:0]);
      exp_trig = '0;
      for (int j = cyc - STRETCH + 1; j <= cyc; j++)
        if (j > last_rst) exp_trig |= 32'(t40_h[j]);

      a   = host.regbridge_ep_address;
      sel = int'(a[TGT_ADDR_LSB +: SEL_W]);
      exp_tw = (host.regbridge_ep_write && sel < N_TGT) ? (32'd1 << sel) : 32'd0;
      exp_tr = (host.regbridge_ep_read && !host.regbridge_ep_write && sel < N_TGT)
               ? (32'd1 << sel) : 32'd0;
      exp_ta = a;
      for (int b = 0; b < SEL_W; b++) exp_ta[TGT_ADDR_LSB + b] = 1'b0;
      exp_td = host.regbridge_ep_dataout;

      while (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        if (p.kind == 0)      exp_din = tgt_datain[32*p.sel +: 32];
        else if (p.kind == 1) exp_din = (p.idx < N_STATUS) ? 32'(cnt_m[p.idx]) : 32'd0;
        else                  exp_din = BAD_WORD;
      end
      if (host.regbridge_ep_read) begin
        p.due = cyc + 2; p.sel = sel; p.idx = int'(a[3:0]);
        if (host.regbridge_ep_write) p.kind = 2;
        else if (sel < N_TGT)        p.kind = 0;
`ifdef FP_CTRL_HUB_EVT_CNT_EN
        else if (sel == N_TGT)       p.kind = 1;
`endif
        else                         p.kind = 2;
        pend.push_back(p);
      end

      for (int i = 0; i < N_STATUS; i++) begin
        if (ti41_ep_trigger[i])              cnt_m[i] = rise[i] ? 1 : 0;
        else if (rise[i] && cnt_m[i] < 255)  cnt_m[i]++;
      end
    end
    #1;
    check("ctrl",      32'(ctrl_out),  exp_ctrl);
    check("trig",      32'(trig_out),  exp_trig);
    check("wo20",      wo20_ep_datain, exp_wo20);
    check("tgt_write", 32'(tgt_write), exp_tw);
    check("tgt_read",  32'(tgt_read),  exp_tr);
    check("tgt_addr",  tgt_address,    exp_ta);
    check("tgt_data",  tgt_dataout,    exp_td);
    check("datain",    host.regbridge_ep_datain, exp_din);
  endtask

  task automatic set_idle();
    host.regbridge_ep_write   = 1'b0;
    host.regbridge_ep_read    = 1'b0;
    host.regbridge_ep_address = '0;
    host.regbridge_ep_dataout = '0;
    tgt_datain      = '0;
    wi00_ep_dataout = '0;
    ti40_ep_trigger = '0;
    ti41_ep_trigger = '0;
    status_in       = '0;
  endtask

  // Pulse trigger bit 3 at step 0 and optionally again at step 'gap'.
  task automatic pulse_test(input int gap);
    int last;
    last = (gap != 0) ? gap : 0;
    for (int i = 0; i < 8; i++) begin
      ti40_ep_trigger = (i == 0 || (gap != 0 && i == gap)) ? 32'h8 : 32'h0;
      cycle();
      check("trig3_dir", 32'(trig_out[3]), (i <= last + STRETCH - 1) ? 32'd1 : 32'd0);
    end
    ti40_ep_trigger = '0;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    cycle(); cycle();
    check("rst_wo20", wo20_ep_datain, 32'd0);
    rst_n = 1'b1;

    // Trigger stretching and retrigger extension.
    pulse_test(0);
    pulse_test(2);

    // Live and sticky status.
    status_in = 8'h04;
    repeat (4) cycle();
    check("wo20_set", wo20_ep_datain, 32'h0004_0004);
    status_in = 8'h00;
    repeat (4) cycle();
    check("wo20_fall", wo20_ep_datain, 32'h0004_0000);

    // Clear sticky, then collide a new edge with a clear: set wins.
    ti41_ep_trigger = 32'h4; cycle(); ti41_ep_trigger = '0;
    repeat (2) cycle();
    check("sticky_cleared", 32'(wo20_ep_datain[18]), 32'd0);
    status_in = 8'h04;
    repeat (2) cycle();
    ti41_ep_trigger = 32'h4; cycle(); ti41_ep_trigger = '0;
    repeat (2) cycle();
    check("sticky_setwins", 32'(wo20_ep_datain[18]), 32'd1);
    ti41_ep_trigger = 32'h4; cycle(); ti41_ep_trigger = '0;
    repeat (2) cycle();
    check("sticky_clear", 32'(wo20_ep_datain[18]), 32'd0);
    status_in = 8'h00;

    // Bridge write to target 1.
    host.regbridge_ep_write   = 1'b1;
    host.regbridge_ep_address = 32'h0000_1010;
    host.regbridge_ep_dataout = 32'hA5A5_5A5A;
    cycle();
    host.regbridge_ep_write = 1'b0;
    check("wr_strobe", 32'(tgt_write), 32'h2);
    check("wr_addr",   tgt_address,    32'h0000_0010);
    check("wr_data",   tgt_dataout,    32'hA5A5_5A5A);
    cycle();
    check("wr_oneshot", 32'(tgt_write), 32'h0);

    // Bridge read from target 0 with 3-cycle return.
    host.regbridge_ep_read    = 1'b1;
    host.regbridge_ep_address = 32'h0000_0008;
    cycle();
    host.regbridge_ep_read = 1'b0;
    check("rd_strobe", 32'(tgt_read), 32'h1);
    cycle();
    tgt_datain[31:0] = 32'h1234_5678;
    cycle();
    check("rd_data", host.regbridge_ep_datain, 32'h1234_5678);
    tgt_datain = '0;

    // Out-of-range read.
    host.regbridge_ep_read    = 1'b1;
    host.regbridge_ep_address = 32'h0000_3000;
    cycle();
    host.regbridge_ep_read = 1'b0;
    check("rd_oor_strobe", 32'(tgt_read), 32'h0);
    repeat (2) cycle();
    check("rd_oor_data", host.regbridge_ep_datain, BAD_WORD);

    // Read and write together: write forwarded, read returns the bad word.
    host.regbridge_ep_read    = 1'b1;
    host.regbridge_ep_write   = 1'b1;
    host.regbridge_ep_address = 32'h0000_0000;
    cycle();
    host.regbridge_ep_read  = 1'b0;
    host.regbridge_ep_write = 1'b0;
    check("rw_wstrobe", 32'(tgt_write), 32'h1);
    check("rw_rstrobe", 32'(tgt_read),  32'h0);
    repeat (2) cycle();
    check("rw_data", host.regbridge_ep_datain, BAD_WORD);

`ifdef FP_CTRL_HUB_EVT_CNT_EN
    // 300 rising edges saturate counter 0 at 255.
    for (int i = 0; i < 600; i++) begin
      status_in[0] = ~status_in[0];
      cycle();
    end
    status_in = '0;
    repeat (3) cycle();
    host.regbridge_ep_read    = 1'b1;
    host.regbridge_ep_address = 32'(N_TGT) << TGT_ADDR_LSB;
    cycle();
    host.regbridge_ep_read = 1'b0;
    check("cnt_strobe", 32'(tgt_read), 32'h0);
    repeat (2) cycle();
    check("cnt_sat", host.regbridge_ep_datain, 32'h0000_00FF);
`endif

    // Reset in the middle of a read: strobe dropped, data cleared, no replay.
    host.regbridge_ep_read    = 1'b1;
    host.regbridge_ep_address = 32'h0000_1000;
    cycle();
    host.regbridge_ep_read = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_strobe", 32'(tgt_read), 32'h0);
    check("rst_datain", host.regbridge_ep_datain, 32'h0);
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    check("no_replay", host.regbridge_ep_datain, 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) status_in[$urandom_range(0, N_STATUS-1)] ^= 1'b1;
      ti40_ep_trigger = $urandom & $urandom & $urandom;
      ti41_ep_trigger = $urandom & $urandom & $urandom;
      wi00_ep_dataout = $urandom;
      host.regbridge_ep_write   = ($urandom_range(0, 3) == 0);
      host.regbridge_ep_read    = ($urandom_range(0, 1) == 0);
      host.regbridge_ep_address = $urandom;
      host.regbridge_ep_dataout = $urandom;
      for (int k = 0; k < N_TGT; k++) tgt_datain[32*k +: 32] = $urandom;
      rst_n = (i % 500 == 499) ? 1'b0 : 1'b1;
      cycle();
    end
    rst_n = 1'b1;
    set_idle();
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
